// File: rtl/tt_mult_seq_if.sv
// Handshake, weight-bus and status signals of the ternary-weight multiply sequencer.
// The slave view belongs to the sequencer; the master view belongs to its environment.
interface tt_mult_seq_if #(
    parameter int BIT_WIDTH = 8,
    parameter int W_BITS    = 196
);
    logic                   cfg_valid;
    logic                   cfg_ready;
    logic [7:0]             cfg_byte;

    logic                   vec_valid;
    logic                   vec_ready;
    logic [2*BIT_WIDTH-1:0] vec_in;

    logic                   out_valid;
    logic                   out_ready;
    logic [BIT_WIDTH-1:0]   out_data;
    logic [2:0]             out_idx;

    logic [W_BITS-1:0]      mult_w;
    logic [2*BIT_WIDTH-1:0] mult_vec;
    logic [2:0]             mult_row;
    logic                   mult_en;
    logic [BIT_WIDTH-1:0]   mult_out;

    logic                   w_loaded;
    logic                   busy;
    logic                   done;

    modport slave (
        input  cfg_valid, cfg_byte, vec_valid, vec_in, out_ready, mult_out,
        output cfg_ready, vec_ready, out_valid, out_data, out_idx,
               mult_w, mult_vec, mult_row, mult_en, w_loaded, busy, done
    );

    modport master (
        output cfg_valid, cfg_byte, vec_valid, vec_in, out_ready, mult_out,
        input  cfg_ready, vec_ready, out_valid, out_data, out_idx,
               mult_w, mult_vec, mult_row, mult_en, w_loaded, busy, done
    );
endinterface

// File: rtl/tt_mult_seq.sv
// Sequencer for a ternary-weight multiplier: loads the weight bus byte-wise, streams
// OUT_LEN input beats into the datapath, then drains OUT_LEN results through a handshake.
module tt_mult_seq #(
    parameter int OUT_LEN   = 7,
    parameter int BIT_WIDTH = 8,
    parameter int W_BITS    = 196
) (
    input logic         clk,
    input logic         rst,
    tt_mult_seq_if.slave bus
);

    localparam int                 N_BYTES   = (W_BITS + 7) / 8;
    localparam int                 BCNT_W    = $clog2(N_BYTES);
    localparam int                 TAIL_BITS = W_BITS - 8 * (N_BYTES - 1);
    localparam logic [BCNT_W-1:0]  LAST_BYTE = BCNT_W'(N_BYTES - 1);
    localparam logic [2:0]         LAST_ELEM = 3'(OUT_LEN - 1);
    localparam logic [2:0]         ALL_BEATS = 3'(OUT_LEN);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ACCUM,
        ST_SETTLE,
        ST_DRAIN
    } state_e;

    state_e                 state_q, state_d;
    logic [W_BITS-1:0]      mult_w_q, mult_w_d;
    logic                   w_loaded_q, w_loaded_d;
    logic [BCNT_W-1:0]      byte_q, byte_d;
    logic [2:0]             beat_q, beat_d;
    logic [2:0]             elem_q, elem_d;
    logic [2:0]             row_q, row_d;
    logic [2*BIT_WIDTH-1:0] vec_q, vec_d;
    logic                   en_q, en_d;
    logic                   done_q, done_d;

    logic cfg_fire, vec_fire, out_fire;

    // beat_q == ALL_BEATS marks the cycle in which the last beat is presented to the datapath
    assign bus.cfg_ready = (state_q == ST_LOAD);
    assign bus.vec_ready = (state_q == ST_ACCUM) && (beat_q != ALL_BEATS);
    assign bus.out_valid = (state_q == ST_DRAIN);
    assign bus.out_idx   = elem_q;
    assign bus.out_data  = (state_q == ST_DRAIN) ? bus.mult_out : '0;
    assign bus.mult_row  = (state_q == ST_DRAIN) ? elem_q : row_q;
    assign bus.mult_w    = mult_w_q;
    assign bus.mult_vec  = vec_q;
    assign bus.mult_en   = en_q;
    assign bus.w_loaded  = w_loaded_q;
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.done      = done_q;

    assign cfg_fire = bus.cfg_valid && bus.cfg_ready;
    assign vec_fire = bus.vec_valid && bus.vec_ready;
    assign out_fire = bus.out_valid && bus.out_ready;

    always_comb begin
        // NOTE: every next-state signal is defaulted first so no path leaves one unassigned (no latches).
        state_d    = state_q;
        mult_w_d   = mult_w_q;
        w_loaded_d = w_loaded_q;
        byte_d     = byte_q;
        beat_d     = beat_q;
        elem_d     = elem_q;
        row_d      = row_q;
        vec_d      = vec_q;
        en_d       = 1'b0;
        done_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.cfg_valid) begin
                    state_d    = ST_LOAD;
                    w_loaded_d = 1'b0;
                end else if (bus.vec_valid && w_loaded_q) begin
                    state_d = ST_ACCUM;
                end
            end

            ST_LOAD: begin
                if (cfg_fire) begin
                    for (int k = 0; k < N_BYTES - 1; k++) begin
                        if (byte_q == BCNT_W'(k)) mult_w_d[8*k +: 8] = bus.cfg_byte;
                    end
                    // the final byte only partly overlaps the weight bus
                    if (byte_q == LAST_BYTE) begin
                        mult_w_d[W_BITS-1:8*(N_BYTES-1)] = bus.cfg_byte[TAIL_BITS-1:0];
                        state_d    = ST_IDLE;
                        w_loaded_d = 1'b1;
                        byte_d     = '0;
                    end else begin
                        byte_d = byte_q + 1'b1;
                    end
                end
            end

            ST_ACCUM: begin
                if (vec_fire) begin
                    vec_d  = bus.vec_in;
                    row_d  = beat_q;
                    en_d   = 1'b1;
                    beat_d = beat_q + 1'b1;
                end else if (beat_q == ALL_BEATS) begin
                    state_d = ST_SETTLE;
                    beat_d  = '0;
                end
            end

            ST_SETTLE: state_d = ST_DRAIN;

            ST_DRAIN: begin
                if (out_fire) begin
                    if (elem_q == LAST_ELEM) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                        elem_d  = '0;
                    end else begin
                        elem_d = elem_q + 1'b1;
                    end
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the weight register is visible on the mult_w port, so it is cleared like any control flop.
            state_q    <= ST_IDLE;
            mult_w_q   <= '0;
            w_loaded_q <= 1'b0;
            byte_q     <= '0;
            beat_q     <= '0;
            elem_q     <= '0;
            row_q      <= '0;
            vec_q      <= '0;
            en_q       <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge value of the others.
            state_q    <= state_d;
            mult_w_q   <= mult_w_d;
            w_loaded_q <= w_loaded_d;
            byte_q     <= byte_d;
            beat_q     <= beat_d;
            elem_q     <= elem_d;
            row_q      <= row_d;
            vec_q      <= vec_d;
            en_q       <= en_d;
            done_q     <= done_d;
        end
    end

endmodule

// File: tb/tb_tt_mult_seq.sv
// Self-checking bench for tt_mult_seq: byte-array weight model, beat/element scoreboard,
// and a table-driven stand-in for the multiplier datapath.
module tb_tt_mult_seq;

    localparam int BW = 8;
    localparam int WB = 196;
    localparam int OL = 7;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    tt_mult_seq_if #(.BIT_WIDTH(BW), .W_BITS(WB)) bus ();

    tt_mult_seq #(.OUT_LEN(OL), .BIT_WIDTH(BW), .W_BITS(WB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // datapath stand-in: result for element r is dp[r]
    logic [7:0] dp [8];
    assign bus.mult_out = dp[bus.mult_row];

    logic [199:0] w_wide;
    logic         w_loaded_exp;
    logic [2:0]   exp_row;
    logic [15:0]  exp_vec;
    logic [7:0]   load_bytes [25];
    logic [15:0]  beats [7];
    int           n_chk;
    int           n_fail;

    task automatic test_reset(input string tag);
        rst = 1'b1;
        @(posedge clk); #1;
        w_wide = '0; w_loaded_exp = 1'b0; exp_row = '0; exp_vec = '0;
        n_chk++;
        if (bus.cfg_ready !== 1'b0 || bus.vec_ready !== 1'b0 || bus.out_valid !== 1'b0 ||
            bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_rst_handshake: cfg_rdy=%b vec_rdy=%b out_vld=%b busy=%b done=%b, want all 0",
                     tag, bus.cfg_ready, bus.vec_ready, bus.out_valid, bus.busy, bus.done);
        end
        n_chk++;
        if (bus.out_idx !== 3'd0 || bus.mult_row !== 3'd0 || bus.mult_en !== 1'b0 || bus.mult_vec !== 16'h0) begin
            n_fail++;
            $display("FAIL %s_rst_datapath: idx=%0d row=%0d en=%b vec=%h, want 0 0 0 0000",
                     tag, bus.out_idx, bus.mult_row, bus.mult_en, bus.mult_vec);
        end
        n_chk++;
        if (bus.mult_w !== '0 || bus.w_loaded !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_rst_weights: w_loaded=%b mult_w=%h, want 0 and 0", tag, bus.w_loaded, bus.mult_w);
        end
        rst = 1'b0;
        bus.cfg_valid = 1'b0; bus.vec_valid = 1'b0; bus.out_ready = 1'b0;
    endtask

    task automatic test_gating_idle();
        bus.vec_valid = 1'b1;
        bus.vec_in    = 16'h1234;
        for (int c = 0; c < 16; c++) begin
            @(posedge clk); #1;
            n_chk++;
            if (bus.vec_ready !== 1'b0 || bus.busy !== 1'b0) begin
                n_fail++;
                $display("FAIL gate_unloaded: cycle %0d vec_rdy=%b busy=%b, want 0 0", c, bus.vec_ready, bus.busy);
            end
        end
        bus.vec_valid = 1'b0;
    endtask

    // Loads load_bytes[0..stop_at-1]; stop_at < 25 leaves the block mid-load.
    task automatic test_load(input bit prio, input bit gaps, input int stop_at);
        int   k   = 0;
        int   cyc = 0;
        logic acc;
        bus.cfg_valid = 1'b1;
        bus.cfg_byte  = load_bytes[0];
        bus.vec_valid = prio;
        bus.vec_in    = 16'hBEEF;
        @(posedge clk); #1;
        w_loaded_exp = 1'b0;
        n_chk++;
        if (bus.cfg_ready !== 1'b1 || bus.vec_ready !== 1'b0 || bus.w_loaded !== 1'b0 || bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL load_entry: cfg_rdy=%b vec_rdy=%b w_loaded=%b busy=%b, want 1 0 0 1",
                     bus.cfg_ready, bus.vec_ready, bus.w_loaded, bus.busy);
        end
        bus.vec_valid = 1'b0;
        while (k < stop_at && cyc < 400) begin
            n_chk++;
            if (bus.cfg_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL load_ready: byte %0d cfg_rdy=%b, want 1", k, bus.cfg_ready);
            end
            bus.cfg_valid = !gaps || ($urandom_range(0, 2) != 0);
            bus.cfg_byte  = load_bytes[k];
            acc = bus.cfg_valid;
            @(posedge clk); #1;
            cyc++;
            if (acc) begin
                w_wide[8*k +: 8] = load_bytes[k];
                k++;
            end
            n_chk++;
            if (bus.mult_w !== w_wide[WB-1:0]) begin
                n_fail++;
                $display("FAIL load_mult_w: after %0d bytes got %h want %h", k, bus.mult_w, w_wide[WB-1:0]);
            end
            if (k == 25) begin
                w_loaded_exp = 1'b1;
                n_chk++;
                if (bus.w_loaded !== 1'b1 || bus.busy !== 1'b0 || bus.cfg_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL load_complete: w_loaded=%b busy=%b cfg_rdy=%b, want 1 0 0",
                             bus.w_loaded, bus.busy, bus.cfg_ready);
                end
            end else begin
                n_chk++;
                if (bus.w_loaded !== 1'b0) begin
                    n_fail++;
                    $display("FAIL load_w_loaded_early: after %0d bytes w_loaded=%b, want 0", k, bus.w_loaded);
                end
            end
        end
        bus.cfg_valid = 1'b0;
        n_chk++;
        if (k !== stop_at) begin
            n_fail++;
            $display("FAIL load_timeout: accepted %0d bytes, want %0d", k, stop_at);
        end
    endtask

    task automatic test_load_vector();
        logic [WB-1:0] w;
        w = bus.mult_w;
        n_chk++;
        if (w[7:0] !== 8'h00 || w[191:184] !== 8'h17 || w[195:192] !== 4'hB || bus.w_loaded !== 1'b1) begin
            n_fail++;
            $display("FAIL load_vector: w[7:0]=%h w[191:184]=%h w[195:192]=%h w_loaded=%b, want 00 17 b 1",
                     w[7:0], w[191:184], w[195:192], bus.w_loaded);
        end
    endtask

    // One full pass; stall_e/stall_n hold out_ready low at that element, chain re-enters ACCUM on done.
    task automatic test_pass(input bit from_accum, input bit throttle, input int stall_e,
                             input int stall_n, input bit cfg_poke, input bit chain);
        int   sent  = 0;
        int   cyc   = 0;
        int   e     = 0;
        int   stall = 0;
        logic exp_rdy, acc;
        while (sent < OL && cyc < 200) begin
            exp_rdy = from_accum || (cyc > 0);
            n_chk++;
            if (bus.vec_ready !== exp_rdy) begin
                n_fail++;
                $display("FAIL accum_vec_ready: cycle %0d got %b want %b", cyc, bus.vec_ready, exp_rdy);
            end
            bus.vec_valid = !throttle || (cyc % 2 == 0);
            bus.vec_in    = beats[sent];
            acc = bus.vec_valid && exp_rdy;
            @(posedge clk); #1;
            cyc++;
            if (acc) begin
                exp_row = 3'(sent);
                exp_vec = beats[sent];
                sent++;
            end
            n_chk++;
            if (bus.mult_en !== acc || bus.mult_row !== exp_row || bus.mult_vec !== exp_vec || bus.out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL accum_issue: cycle %0d en=%b row=%0d vec=%h out_vld=%b, want en=%b row=%0d vec=%h out_vld=0",
                         cyc, bus.mult_en, bus.mult_row, bus.mult_vec, bus.out_valid, acc, exp_row, exp_vec);
            end
        end
        bus.vec_valid = 1'b0;
        n_chk++;
        if (sent !== OL) begin
            n_fail++;
            $display("FAIL accum_timeout: issued %0d beats, want %0d", sent, OL);
        end

        @(posedge clk); #1;
        n_chk++;
        if (bus.mult_en !== 1'b0 || bus.out_valid !== 1'b0 || bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL settle: en=%b out_vld=%b busy=%b, want 0 0 1", bus.mult_en, bus.out_valid, bus.busy);
        end
        @(posedge clk); #1;

        cyc = 0;
        while (e < OL && cyc < 200) begin
            n_chk++;
            if (bus.out_valid !== 1'b1 || bus.out_idx !== 3'(e) || bus.out_data !== dp[e] ||
                bus.mult_row !== 3'(e) || bus.done !== 1'b0 || bus.mult_en !== 1'b0) begin
                n_fail++;
                $display("FAIL drain_elem: e=%0d vld=%b idx=%0d data=%h row=%0d done=%b en=%b, want 1 %0d %h %0d 0 0",
                         e, bus.out_valid, bus.out_idx, bus.out_data, bus.mult_row, bus.done, bus.mult_en, e, dp[e], e);
            end
            if (cfg_poke) begin
                n_chk++;
                if (bus.cfg_ready !== 1'b0 || bus.mult_w !== w_wide[WB-1:0]) begin
                    n_fail++;
                    $display("FAIL drain_cfg_gate: cfg_rdy=%b mult_w=%h, want 0 and %h",
                             bus.cfg_ready, bus.mult_w, w_wide[WB-1:0]);
                end
            end
            bus.cfg_valid = cfg_poke && (e < OL - 1);
            bus.cfg_byte  = 8'($urandom);
            bus.out_ready = !(e == stall_e && stall < stall_n);
            if (!bus.out_ready) stall++;
            acc = bus.out_ready;
            @(posedge clk); #1;
            cyc++;
            if (acc) e++;
        end
        bus.out_ready = 1'b0;
        bus.cfg_valid = 1'b0;
        n_chk++;
        if (e !== OL || bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.w_loaded !== 1'b1) begin
            n_fail++;
            $display("FAIL pass_done: elems=%0d done=%b busy=%b out_vld=%b w_loaded=%b, want %0d 1 0 0 1",
                     e, bus.done, bus.busy, bus.out_valid, bus.w_loaded, OL);
        end
        bus.vec_valid = chain;
        @(posedge clk); #1;
        n_chk++;
        if (bus.done !== 1'b0 || bus.busy !== chain || bus.vec_ready !== chain) begin
            n_fail++;
            $display("FAIL pass_after_done: done=%b busy=%b vec_rdy=%b, want 0 %b %b",
                     bus.done, bus.busy, bus.vec_ready, chain, chain);
        end
        bus.vec_valid = 1'b0;
    endtask

    task automatic test_reset_drain();
        int sent = 0;
        int e    = 0;
        int cyc  = 0;
        while (!(bus.out_valid && e == 4) && cyc < 100) begin
            bus.vec_valid = (sent < OL);
            bus.vec_in    = 16'($urandom);
            if (bus.vec_valid && bus.vec_ready) sent++;
            bus.out_ready = bus.out_valid && (e < 4);
            if (bus.out_ready) e++;
            @(posedge clk); #1;
            cyc++;
        end
        n_chk++;
        if (bus.out_valid !== 1'b1 || bus.out_idx !== 3'd4) begin
            n_fail++;
            $display("FAIL drain_reach_e4: out_vld=%b idx=%0d, want 1 4", bus.out_valid, bus.out_idx);
        end
        bus.out_ready = 1'b1;
        test_reset("mid_drain");
    endtask

    task automatic new_pass_data(input bit ramp);
        for (int i = 0; i < OL; i++) beats[i] = ramp ? 16'((i + 1) * 16'h0101) : 16'($urandom);
        for (int i = 0; i < 8; i++) dp[i] = 8'($urandom);
    endtask

    initial begin
        n_chk = 0; n_fail = 0;
        bus.cfg_valid = 1'b0; bus.cfg_byte = '0;
        bus.vec_valid = 1'b0; bus.vec_in = '0;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 8; i++) dp[i] = '0;

        test_reset("initial");
        test_gating_idle();

        for (int i = 0; i < 24; i++) load_bytes[i] = 8'(i);
        load_bytes[24] = 8'hAB;
        test_load(1'b0, 1'b0, 25);
        test_load_vector();

        new_pass_data(1'b1);
        test_pass(1'b0, 1'b0, -1, 0, 1'b0, 1'b0);
        new_pass_data(1'b0);
        test_pass(1'b0, 1'b1, 2, 3, 1'b0, 1'b1);
        new_pass_data(1'b0);
        test_pass(1'b1, 1'b0, -1, 0, 1'b1, 1'b0);

        for (int i = 0; i < 25; i++) load_bytes[i] = 8'($urandom);
        test_load(1'b1, 1'b1, 25);
        new_pass_data(1'b0);
        test_pass(1'b0, 1'b1, 5, 2, 1'b0, 1'b0);

        for (int i = 0; i < 25; i++) load_bytes[i] = 8'($urandom);
        test_load(1'b0, 1'b0, 11);
        test_reset("mid_load");
        test_gating_idle();

        test_load(1'b0, 1'b1, 25);
        test_reset_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
